// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state, owner encodings and counter width for the memory port arbiter.
package mem_arb_pkg;
  localparam int LAT_CNT_W = 4;
  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_e;
  typedef enum logic {OWN_IF = 1'b0, OWN_D = 1'b1} owner_e;
endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational winner select; ARB_ROUND_ROBIN_EN selects round-robin,
// otherwise D has priority with a starvation guard for IF.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic                 if_req,
  input  logic                 d_req,
`ifdef ARB_ROUND_ROBIN_EN
  input  owner_e               ptr,
`else
  input  logic [LAT_CNT_W-1:0] starve_cnt,
`endif
  output owner_e               winner
);
`ifdef ARB_ROUND_ROBIN_EN
  assign winner = (if_req && d_req) ? ptr : (d_req ? OWN_D : OWN_IF);
`else
  assign winner = (d_req && !(if_req && starve_cnt == LAT_CNT_W'(STARVE_MAX))) ? OWN_D : OWN_IF;
`endif
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and data requesters, one access at a time.
// ARB_ROUND_ROBIN_EN switches arbitration from D-priority-with-starvation-guard to round-robin.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  state_e               state, state_nx;
  owner_e               owner, winner;
  logic                 we_q, start, issue, resp;
  logic [ADDR_W-1:0]    addr_q;
  logic [DATA_W-1:0]    wdata_q;
  logic [LAT_CNT_W-1:0] lat_cnt;
`ifdef ARB_ROUND_ROBIN_EN
  owner_e ptr;
  mem_arb_pick #(.STARVE_MAX(STARVE_MAX)) u_pick (
    .if_req(if_req), .d_req(d_req), .ptr(ptr), .winner(winner)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) ptr <= OWN_D;
    else if (start) ptr <= (winner == OWN_D) ? OWN_IF : OWN_D;
`else
  logic [LAT_CNT_W-1:0] starve_cnt;
  mem_arb_pick #(.STARVE_MAX(STARVE_MAX)) u_pick (
    .if_req(if_req), .d_req(d_req), .starve_cnt(starve_cnt), .winner(winner)
  );
  // counts D wins that bypassed a waiting fetch; never exceeds STARVE_MAX since IF then wins
  always_ff @(posedge clk or posedge reset)
    if (reset) starve_cnt <= '0;
    else if (!if_req || (start && winner == OWN_IF)) starve_cnt <= '0;
    else if (start) starve_cnt <= starve_cnt + 1'b1;
`endif
  assign start     = (state == ST_IDLE) && (if_req || d_req);
  assign issue     = state == ST_ISSUE;
  assign resp      = state == ST_RESP;
  assign mem_en    = issue;
  assign mem_we    = issue && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign if_gnt    = issue && owner == OWN_IF;
  assign d_gnt     = issue && owner == OWN_D;
  assign if_rvalid = resp && owner == OWN_IF;
  assign d_rvalid  = resp && owner == OWN_D;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= ST_IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:  state_nx = start ? ST_ISSUE : ST_IDLE;
      ST_ISSUE: state_nx = we_q ? ST_IDLE : ST_WAIT;
      ST_WAIT:  state_nx = (lat_cnt == '0) ? ST_RESP : ST_WAIT;
      default:  state_nx = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      owner    <= OWN_IF;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      lat_cnt  <= '0;
      if_rdata <= '0;
      d_rdata  <= '0;
    end else begin
      if (start) begin
        owner   <= winner;
        we_q    <= (winner == OWN_D) && d_we;
        addr_q  <= (winner == OWN_D) ? d_addr : if_addr;
        wdata_q <= d_wdata;
      end
      if (issue) lat_cnt <= LAT_CNT_W'(MEM_LAT - 1);
      else if (state == ST_WAIT) lat_cnt <= lat_cnt - 1'b1;
      if (state == ST_WAIT && lat_cnt == '0) begin
        if (owner == OWN_D) d_rdata <= mem_rdata;
        else if_rdata <= mem_rdata;
      end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed and random checks of the arbiter against a transaction-level model.
// Honours ARB_ROUND_ROBIN_EN for the expected grant order.
module tb_mem_port_arbiter;
  localparam int LAT = 2, SMAX = 4, NC = 4096;
  logic clk = 0, reset = 1;
  logic if_req = 0, d_req = 0, d_we = 0;
  logic [31:0] if_addr = 0, d_addr = 0, d_wdata = 0, mem_rdata = 0;
  logic if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic d1_req = 0;
  logic [31:0] d1_addr = 0, mem1_rdata = 0;
  logic if1_gnt, if1_rvalid, d1_gnt, d1_rvalid, mem1_en, mem1_we;
  logic [31:0] if1_rdata, d1_rdata, mem1_addr, mem1_wdata;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(SMAX)) dut1 (
    .clk(clk), .reset(reset),
    .if_req(1'b0), .if_addr(32'h0), .if_gnt(if1_gnt), .if_rvalid(if1_rvalid), .if_rdata(if1_rdata),
    .d_req(d1_req), .d_we(1'b0), .d_addr(d1_addr), .d_wdata(32'h0),
    .d_gnt(d1_gnt), .d_rvalid(d1_rvalid), .d_rdata(d1_rdata),
    .mem_en(mem1_en), .mem_we(mem1_we), .mem_addr(mem1_addr), .mem_wdata(mem1_wdata), .mem_rdata(mem1_rdata)
  );

  always #5 clk = ~clk;

  bit e_ig[NC], e_dg[NC], e_en[NC], e_we[NC], e_irv[NC], e_drv[NC], rd_v[NC];
  logic [31:0] e_addr[NC], e_wd[NC], e_rd[NC], rd_d[NC];
  logic [31:0] bmem[logic [31:0]], mmem[logic [31:0]];
  int cyc = 0, checks = 0, errors = 0, starve = 0, free_at = 0;
  bit ptr_d = 1;
  logic [31:0] x_ird = 0, x_drd = 0;
  logic s_en = 0, s_we = 0, s_ig = 0, s_dg = 0;
  logic [31:0] s_addr = 0, s_wd = 0;

  function automatic logic [31:0] ival(input logic [31:0] a);
    return a * 32'h9E37_79B9 + 32'h1234_5678;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = cyc; i < NC; i++) begin
      e_ig[i] = 0; e_dg[i] = 0; e_en[i] = 0; e_we[i] = 0; e_irv[i] = 0; e_drv[i] = 0; rd_v[i] = 0;
    end
    starve = 0; free_at = 0; ptr_d = 1; x_ird = 0; x_drd = 0;
  endtask

  // one clock: check this cycle at negedge, advance model and bench memory at posedge, drive memory data
  task automatic cycle();
    bit wd;
    logic [31:0] a;
    @(negedge clk);
    if (e_irv[cyc]) x_ird = e_rd[cyc];
    if (e_drv[cyc]) x_drd = e_rd[cyc];
    chk("if_gnt", if_gnt, e_ig[cyc]);
    chk("d_gnt", d_gnt, e_dg[cyc]);
    chk("if_rvalid", if_rvalid, e_irv[cyc]);
    chk("d_rvalid", d_rvalid, e_drv[cyc]);
    chk("mem_en", mem_en, e_en[cyc]);
    if (e_en[cyc]) begin
      chk("mem_we", mem_we, e_we[cyc]);
      chk("mem_addr", mem_addr, e_addr[cyc]);
      if (e_we[cyc]) chk("mem_wdata", mem_wdata, e_wd[cyc]);
    end
    chk("if_rdata", if_rdata, x_ird);
    chk("d_rdata", d_rdata, x_drd);
    s_en = mem_en; s_we = mem_we; s_addr = mem_addr; s_wd = mem_wdata; s_ig = if_gnt; s_dg = d_gnt;
    @(posedge clk);
    if (!reset) begin
      if (s_en) begin
        if (s_we) bmem[s_addr] = s_wd;
        else begin
          rd_v[cyc+LAT] = 1;
          rd_d[cyc+LAT] = bmem.exists(s_addr) ? bmem[s_addr] : ival(s_addr);
        end
      end
      if (cyc >= free_at && (if_req || d_req)) begin
`ifdef ARB_ROUND_ROBIN_EN
        wd = d_req && (!if_req || ptr_d);
        ptr_d = !wd;
`else
        wd = d_req && !(if_req && starve == SMAX);
        if (!wd) starve = 0;
        else if (if_req) starve++;
`endif
        a = wd ? d_addr : if_addr;
        e_en[cyc+1] = 1; e_ig[cyc+1] = !wd; e_dg[cyc+1] = wd;
        e_we[cyc+1] = wd && d_we; e_addr[cyc+1] = a; e_wd[cyc+1] = d_wdata;
        if (wd && d_we) begin
          mmem[a] = d_wdata;
          free_at = cyc + 2;
        end else begin
          e_rd[cyc+2+LAT] = mmem.exists(a) ? mmem[a] : ival(a);
          e_irv[cyc+2+LAT] = !wd; e_drv[cyc+2+LAT] = wd;
          free_at = cyc + 3 + LAT;
        end
      end
      if (!if_req) starve = 0;
    end
    cyc++;
    #1;
    mem_rdata = rd_v[cyc] ? rd_d[cyc] : $urandom;
  endtask

  initial begin
    int n, k, ng;
    logic [5:0] seq, exp_seq;
    mmem[32'h10] = 32'hDEAD_BEEF;
    bmem[32'h10] = 32'hDEAD_BEEF;
    model_reset();
    repeat (3) cycle();
    chk("rst_mem_en", mem_en, 0);
    chk("rst_rdata", if_rdata, 0);
    reset = 0;
    cycle();
    // lone fetch read
    if_req = 1; if_addr = 32'h10;
    cycle();
    chk("t1_gnt", if_gnt, 1); chk("t1_en", mem_en, 1); chk("t1_addr", mem_addr, 32'h10);
    if_req = 0;
    repeat (3) cycle();
    chk("t1_rvalid", if_rvalid, 1); chk("t1_rdata", if_rdata, 32'hDEAD_BEEF);
    repeat (2) cycle();
    // data write, held request reissues two cycles later
    d_req = 1; d_we = 1; d_addr = 32'h20; d_wdata = 32'h5A;
    cycle();
    chk("t2_gnt", d_gnt, 1); chk("t2_we", mem_we, 1); chk("t2_wdata", mem_wdata, 32'h5A);
    cycle();
    chk("t2_gap", mem_en, 0);
    cycle();
    chk("t2_again", d_gnt, 1);
    d_req = 0; d_we = 0;
    n = 0;
    repeat (6) begin cycle(); n += int'(d_rvalid); end
    chk("t2_no_rvalid", n, 0);
    // both requesters held: grant order
    reset = 1; model_reset(); cycle(); reset = 0; cycle();
    if_req = 1; if_addr = 32'h44; d_req = 1; d_we = 1; d_addr = 32'h48; d_wdata = 32'h1111_2222;
    ng = 0; k = 0; seq = 0;
    while (ng < 6 && k < 200) begin
      cycle(); k++;
      if (if_gnt) begin seq[ng] = 1'b0; ng++; end
      else if (d_gnt) begin seq[ng] = 1'b1; ng++; end
    end
    chk("t3_grants", ng, 6);
`ifdef ARB_ROUND_ROBIN_EN
    exp_seq = 6'b010101;
`else
    exp_seq = 6'b101111;
`endif
    chk("t3_order", {26'b0, seq}, {26'b0, exp_seq});
    if_req = 0; d_req = 0; d_we = 0;
    repeat (12) cycle();
    // reset during WAIT aborts the access
    if_req = 1; if_addr = 32'h18;
    cycle();
    if_req = 0;
    cycle();
    reset = 1; model_reset();
    #1;
    chk("t5_en", mem_en, 0); chk("t5_rvalid", if_rvalid, 0); chk("t5_rdata", if_rdata, 0);
    n = 0;
    repeat (2) begin cycle(); n += int'(if_rvalid); end
    reset = 0;
    repeat (4) begin cycle(); n += int'(if_rvalid); end
    chk("t5_no_rvalid", n, 0);
    if_req = 1; if_addr = 32'h30;
    cycle();
    chk("t5_gnt", if_gnt, 1);
    if_req = 0;
    repeat (3) cycle();
    chk("t5_rvalid2", if_rvalid, 1); chk("t5_rdata2", if_rdata, ival(32'h30));
    // random traffic
    for (int i = 0; i < 1500; i++) begin
      if (s_ig || !if_req) begin
        if_req = $urandom_range(0, 2) != 0;
        if_addr = 32'($urandom_range(0, 7)) << 2;
      end else if ($urandom_range(0, 15) == 0) if_req = 0;
      if (s_dg || !d_req) begin
        d_req = $urandom_range(0, 2) != 0;
        d_we = $urandom_range(0, 1) == 1;
        d_addr = 32'($urandom_range(0, 7)) << 2;
        d_wdata = $urandom;
      end else if ($urandom_range(0, 15) == 0) d_req = 0;
      cycle();
    end
    if_req = 0; d_req = 0;
    repeat (12) cycle();
    // MEM_LAT=1 data read on the second instance
    d1_req = 1; d1_addr = 32'h40; mem1_rdata = $urandom;
    cycle();
    chk("t6_gnt", d1_gnt, 1); chk("t6_en", mem1_en, 1); chk("t6_addr", mem1_addr, 32'h40);
    d1_req = 0;
    cycle();
    chk("t6_wait", d1_rvalid, 0);
    mem1_rdata = 32'hCAFE_F00D;
    cycle();
    chk("t6_rvalid", d1_rvalid, 1); chk("t6_rdata", d1_rdata, 32'hCAFE_F00D);
    mem1_rdata = $urandom;
    cycle();
    chk("t6_pulse", d1_rvalid, 0); chk("t6_hold", d1_rdata, 32'hCAFE_F00D);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
